alu_exec_unit: RTL

Integer execute stage, directly downstream of the ALU opcode decoder; consumes its 5-bit ALUOp code plus two operands and produces a 32-bit result.
- Single-cycle ops (add/sub/logic/shift/compare/multiply) return with registered latency 1.
- Divide/remainder run on an iterative radix-2 divider.
- Valid/ready handshakes on both sides let the pipeline stall during division.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/serial_divider.sv | 64 ++++++
 rtl/alu_exec_unit.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALUOp encodings and execute-stage FSM states.
// Imported by both the opcode decoder and alu_exec_unit.
package alu_pkg;

  localparam int ALU_XLEN = 32;
  localparam int ALU_OPW  = 5;

  localparam logic [4:0] ALU_ADD     = 5'b00000;
  localparam logic [4:0] ALU_SUB     = 5'b00001;
  localparam logic [4:0] ALU_AND     = 5'b00100;
  localparam logic [4:0] ALU_OR      = 5'b00101;
  localparam logic [4:0] ALU_XOR     = 5'b00110;
  localparam logic [4:0] ALU_SLL     = 5'b00111;
  localparam logic [4:0] ALU_SRL     = 5'b01000;
  localparam logic [4:0] ALU_SRA     = 5'b01001;
  localparam logic [4:0] ALU_SLTU    = 5'b01010;
  localparam logic [4:0] ALU_SLT     = 5'b01011;
  localparam logic [4:0] ALU_MUL     = 5'b01100;
  localparam logic [4:0] ALU_MULH    = 5'b01101;
  localparam logic [4:0] ALU_MULHSU  = 5'b10100;
  localparam logic [4:0] ALU_MULHU   = 5'b10001;
  localparam logic [4:0] ALU_DIV     = 5'b10010;
  localparam logic [4:0] ALU_DIVU    = 5'b01110;
  localparam logic [4:0] ALU_REM     = 5'b10011;
  localparam logic [4:0] ALU_REMU    = 5'b01111;
  localparam logic [4:0] ALU_INVALID = 5'b11111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIX  = 2'd2
  } alu_state_e;

endpackage

// File: rtl/serial_divider.sv
// Unsigned restoring radix-2 divider, one quotient bit per clock.
// Operands are magnitudes; sign handling lives in the caller.
module serial_divider #(
  parameter int XLEN       = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_kill,
  input  logic            i_start,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic            o_done,
  output logic [XLEN-1:0] o_quotient,
  output logic [XLEN-1:0] o_remainder
);

  localparam int CW = $clog2(DIV_CYCLES + 1);

  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_dvs;
  logic [CW-1:0]   r_cnt;
  logic            r_done;

  logic [XLEN:0]   w_sh;
  logic [XLEN:0]   w_diff;
  logic            w_ge;

  // Partial remainder shifted left, taking the next dividend bit from the quotient register
  assign w_sh   = {r_rem, r_quo[XLEN-1]};
  assign w_ge   = (w_sh >= {1'b0, r_dvs});
  assign w_diff = w_sh - {1'b0, r_dvs};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_quo  <= '0;
      r_rem  <= '0;
      r_dvs  <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_kill) begin
        r_cnt <= '0;
      end else if (i_start) begin
        r_quo <= i_dividend;
        r_rem <= '0;
        r_dvs <= i_divisor;
        r_cnt <= CW'(DIV_CYCLES);
      end else if (r_cnt != '0) begin
        r_rem  <= w_ge ? w_diff[XLEN-1:0] : w_sh[XLEN-1:0];
        r_quo  <= {r_quo[XLEN-2:0], w_ge};
        r_cnt  <= r_cnt - 1'b1;
        r_done <= (r_cnt == CW'(1));
      end
    end
  end

  assign o_done      = r_done;
  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;

endmodule

// File: rtl/alu_exec_unit.sv
// Integer execute stage: single-cycle ALU ops plus iterative divide, valid/ready on both sides.
// ALU_EXEC_MULDIV_EN enables multiply/divide; without it those codes complete as illegal.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN       = ALU_XLEN,
  parameter int OPW        = ALU_OPW,
  parameter int DIV_CYCLES = XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  alu_op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);

  alu_state_e      r_state;
  alu_state_e      w_state_nxt;

  logic            r_out_valid;
  logic [XLEN-1:0] r_result;
  logic            r_zero;
  logic            r_illegal;

  logic            w_accept;
  logic            w_go_div;
  logic            w_ill;
  logic [XLEN-1:0] w_res;
  logic            w_fix_done;
  logic [XLEN-1:0] w_fix_res;
  logic [SHW-1:0]  w_shamt;

  assign w_shamt  = src_b[SHW-1:0];
  assign in_ready = (r_state == IDLE) && (!r_out_valid || out_ready) && !flush && !rst;
  assign w_accept = in_valid && in_ready;

`ifdef ALU_EXEC_MULDIV_EN
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic              w_mul_sa;
  logic              w_mul_sb;
  logic [2*XLEN-1:0] w_mul_a;
  logic [2*XLEN-1:0] w_mul_b;
  logic [2*XLEN-1:0] w_prod;
  logic              w_div_sgn;
  logic              w_div_rem;
  logic              w_a_neg;
  logic              w_b_neg;
  logic              w_div_zero;
  logic              w_div_ovf;
  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic              w_div_done;
  logic              r_neg_q;
  logic              r_neg_r;
  logic              r_is_rem;

  // Sign-extend to 2*XLEN so one unsigned multiplier serves all high/low variants
  assign w_mul_sa = (alu_op == ALU_MULH) || (alu_op == ALU_MULHSU);
  assign w_mul_sb = (alu_op == ALU_MULH);
  assign w_mul_a  = {{XLEN{w_mul_sa & src_a[XLEN-1]}}, src_a};
  assign w_mul_b  = {{XLEN{w_mul_sb & src_b[XLEN-1]}}, src_b};
  assign w_prod   = w_mul_a * w_mul_b;

  assign w_div_sgn  = (alu_op == ALU_DIV) || (alu_op == ALU_REM);
  assign w_div_rem  = (alu_op == ALU_REM) || (alu_op == ALU_REMU);
  assign w_a_neg    = w_div_sgn & src_a[XLEN-1];
  assign w_b_neg    = w_div_sgn & src_b[XLEN-1];
  assign w_mag_a    = w_a_neg ? -src_a : src_a;
  assign w_mag_b    = w_b_neg ? -src_b : src_b;
  assign w_div_zero = (src_b == '0);
  assign w_div_ovf  = w_div_sgn && (src_a == MIN_NEG) && (&src_b);

  serial_divider #(
    .XLEN       (XLEN),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_kill      (flush),
    .i_start     (w_accept && w_go_div),
    .i_dividend  (w_mag_a),
    .i_divisor   (w_mag_b),
    .o_done      (w_div_done),
    .o_quotient  (w_quo),
    .o_remainder (w_rem)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_is_rem <= 1'b0;
    end else if (w_accept && w_go_div) begin
      r_neg_q  <= w_a_neg ^ w_b_neg;
      r_neg_r  <= w_a_neg;
      r_is_rem <= w_div_rem;
    end
  end

  // Remainder follows the dividend's sign; quotient is negated when signs differ
  assign w_fix_res  = r_is_rem ? (r_neg_r ? -w_rem : w_rem)
                               : (r_neg_q ? -w_quo : w_quo);
  assign w_fix_done = (r_state == FIX) && !flush;
  assign busy       = (r_state != IDLE);
`else
  assign w_fix_res  = '0;
  assign w_fix_done = 1'b0;
  assign busy       = 1'b0;
`endif

  always_comb begin
    w_res    = '0;
    w_ill    = 1'b0;
    w_go_div = 1'b0;
    case (alu_op)
      ALU_ADD:  w_res = src_a + src_b;
      ALU_SUB:  w_res = src_a - src_b;
      ALU_AND:  w_res = src_a & src_b;
      ALU_OR:   w_res = src_a | src_b;
      ALU_XOR:  w_res = src_a ^ src_b;
      ALU_SLL:  w_res = src_a << w_shamt;
      ALU_SRL:  w_res = src_a >> w_shamt;
      ALU_SRA:  w_res = $unsigned($signed(src_a) >>> w_shamt);
      ALU_SLTU: w_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      ALU_SLT:  w_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
`ifdef ALU_EXEC_MULDIV_EN
      ALU_MUL:  w_res = w_prod[XLEN-1:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU:
                w_res = w_prod[2*XLEN-1:XLEN];
      // Zero divisor and signed overflow bypass the divider with fixed answers
      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: begin
        if (w_div_zero)
          w_res = w_div_rem ? src_a : '1;
        else if (w_div_ovf)
          w_res = w_div_rem ? '0 : MIN_NEG;
        else
          w_go_div = 1'b1;
      end
`else
      ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU:
                w_ill = 1'b1;
`endif
      ALU_INVALID: w_ill = 1'b1;
      default:     w_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
`ifdef ALU_EXEC_MULDIV_EN
    case (r_state)
      IDLE:    if (w_accept && w_go_div) w_state_nxt = DIV;
      DIV:     if (w_div_done) w_state_nxt = FIX;
      FIX:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (flush) w_state_nxt = IDLE;
`else
    w_state_nxt = IDLE;
`endif
  end

  // A new completion overrides the drain so back-to-back ops sustain one result per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept && !w_go_div) begin
      r_out_valid <= 1'b1;
      r_result    <= w_res;
      r_zero      <= (w_res == '0);
      r_illegal   <= w_ill;
    end else if (w_fix_done) begin
      r_out_valid <= 1'b1;
      r_result    <= w_fix_res;
      r_zero      <= (w_fix_res == '0);
      r_illegal   <= 1'b0;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign illegal   = r_illegal;

endmodule
